scl_row_packer: RTL and testbench

//  Downstream of the scaler: takes the scaled RGB pixel stream (scl_o_*) and packs bytes into 32-bit words for the frame writer.

---
 rtl/scl_row_packer.sv | 160 ++++++++++++++++
 tb/tb_scl_row_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scl_row_packer.sv
// Packs the scaled RGB pixel stream into 32-bit little-endian words, zero-pads every line
// to a 4-byte boundary and buffers the words in a show-ahead FIFO for the frame writer.
module scl_row_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH_W    = 13
) (
    input  logic                          clk_scl,
    input  logic                          rst_scl,
    input  logic                          scl_o_vsync,
    input  logic                          scl_o_data_en,
    input  logic [7:0]                    scl_o_data_r,
    input  logic [7:0]                    scl_o_data_g,
    input  logic [7:0]                    scl_o_data_b,
    input  logic [WIDTH_W-1:0]            pk_cfg_width,
    output logic                          pk_o_valid,
    input  logic                          pk_i_ready,
    output logic [31:0]                   pk_o_data,
    output logic                          pk_o_sof,
    output logic                          pk_o_eol,
    output logic                          pk_o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   pk_o_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW:0] DEPTH_L = (LW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } word_t;

    logic               vsync_q;
    logic [1:0]         lane_q, lane_d;
    logic [23:0]        asm_q, asm_d;
    logic [WIDTH_W-1:0] cnt_q, cnt_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               sof_pend_q, sof_pend_d;
    logic               ovf_q, ovf_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nx;
    logic [LW-1:0]      level_q, level_d;
    word_t              mem_q [FIFO_DEPTH];

    logic               rise, line_end, push0, push1, sof_base;
    logic [1:0]         lane_base;
    logic [23:0]        asm_base;
    logic [WIDTH_W-1:0] cnt_base;
    logic [2:0]         n_bytes;
    logic [47:0]        merged;
    word_t              word0, word1, head;
    logic               pop, acc0, acc1;
    logic [1:0]         n_acc;
    logic [LW:0]        free;

    // Packing: a vsync rise discards the open word before this cycle's pixel is merged.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
        rise      = scl_o_vsync & ~vsync_q;
        lane_base = rise ? 2'd0 : lane_q;
        asm_base  = rise ? 24'd0 : asm_q;
        cnt_base  = rise ? '0 : cnt_q;
        width_d   = rise ? pk_cfg_width : width_q;
        sof_base  = rise | sof_pend_q;
        merged    = {24'd0, asm_base}
                  | ({24'd0, scl_o_data_b, scl_o_data_g, scl_o_data_r} << {lane_base, 3'b000});
        n_bytes   = {1'b0, lane_base} + 3'd3;
        line_end  = (cnt_base == width_d - WIDTH_W'(1));
        lane_d     = lane_base;
        asm_d      = asm_base;
        cnt_d      = cnt_base;
        sof_pend_d = sof_base;
        push0      = 1'b0;
        push1      = 1'b0;
        word0      = '0;
        word1      = '0;
        if (scl_o_data_en) begin
            cnt_d = line_end ? '0 : cnt_base + WIDTH_W'(1);
            push0 = n_bytes[2] | line_end;
            word0.data = merged[31:0];
            if (line_end) begin
                lane_d = 2'd0;
                asm_d  = 24'd0;
                // A line closing with bytes past the full word needs a second, padded word.
                if (n_bytes > 3'd4) begin
                    push1      = 1'b1;
                    word1.data = {16'd0, merged[47:32]};
                    word1.eol  = 1'b1;
                end else begin
                    word0.eol = 1'b1;
                end
            end else if (n_bytes[2]) begin
                lane_d = n_bytes[1:0];
                asm_d  = {8'd0, merged[47:32]};
            end else begin
                lane_d = 2'd3;
                asm_d  = merged[23:0];
            end
            if (push0) begin
                word0.sof  = sof_base;
                sof_pend_d = 1'b0;
            end
        end
    end

    always_comb begin
        pop       = (level_q != '0) & pk_i_ready;
        free      = DEPTH_L - {1'b0, level_q} + (LW + 1)'(pop);
        acc0      = push0 & (free != '0);
        acc1      = push1 & (free >= (LW + 1)'(2));
        n_acc     = {1'b0, acc0} + {1'b0, acc1};
        ovf_d     = ovf_q | (push0 & ~acc0) | (push1 & ~acc1);
        wr_ptr_nx = wr_ptr_q + PW'(1);
        wr_ptr_d  = wr_ptr_q + PW'(n_acc);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        level_d   = level_q + LW'(n_acc) - LW'(pop);
    end

    always_ff @(posedge clk_scl) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_scl) begin
            vsync_q    <= 1'b0;
            lane_q     <= 2'd0;
            asm_q      <= 24'd0;
            cnt_q      <= '0;
            width_q    <= pk_cfg_width;
            sof_pend_q <= 1'b1;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            vsync_q    <= scl_o_vsync;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            cnt_q      <= cnt_d;
            width_q    <= width_d;
            sof_pend_q <= sof_pend_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // NOTE: storage is not reset; the level counter alone decides which entries are meaningful.
    always_ff @(posedge clk_scl) begin
        if (acc0) mem_q[wr_ptr_q]  <= word0;
        if (acc1) mem_q[wr_ptr_nx] <= word1;
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        pk_o_valid = (level_q != '0);
        pk_o_data  = pk_o_valid ? head.data : 32'd0;
        pk_o_sof   = pk_o_valid & head.sof;
        pk_o_eol   = pk_o_valid & head.eol;
        pk_o_ovf   = ovf_q;
        pk_o_level = level_q;
    end
endmodule

// File: tb/tb_scl_row_packer.sv
// Directed and randomized bench for scl_row_packer, checked every cycle against a
// byte-queue reference model of line packing plus a bounded word queue for the FIFO.
module tb_scl_row_packer;
    localparam int DEPTH = 16;
    localparam int WW    = 13;

    logic          clk_scl = 1'b0;
    logic          rst_scl = 1'b1;
    logic          scl_o_vsync = 1'b0;
    logic          scl_o_data_en = 1'b0;
    logic [7:0]    scl_o_data_r = '0, scl_o_data_g = '0, scl_o_data_b = '0;
    logic [WW-1:0] pk_cfg_width = 13'd4;
    logic          pk_o_valid, pk_i_ready = 1'b1;
    logic [31:0]   pk_o_data;
    logic          pk_o_sof, pk_o_eol, pk_o_ovf;
    logic [4:0]    pk_o_level;

    always #5 clk_scl = ~clk_scl;

    scl_row_packer #(.FIFO_DEPTH(DEPTH), .WIDTH_W(WW)) dut (
        .clk_scl(clk_scl), .rst_scl(rst_scl), .scl_o_vsync(scl_o_vsync),
        .scl_o_data_en(scl_o_data_en), .scl_o_data_r(scl_o_data_r),
        .scl_o_data_g(scl_o_data_g), .scl_o_data_b(scl_o_data_b),
        .pk_cfg_width(pk_cfg_width), .pk_o_valid(pk_o_valid), .pk_i_ready(pk_i_ready),
        .pk_o_data(pk_o_data), .pk_o_sof(pk_o_sof), .pk_o_eol(pk_o_eol),
        .pk_o_ovf(pk_o_ovf), .pk_o_level(pk_o_level)
    );

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eol;
    } word_t;

    word_t      m_fifo[$];
    logic [7:0] m_line[$];
    int         m_width, m_pix, m_gen;
    bit         m_sof, m_ovf, m_vprev;
    word_t      acc_q[$];
    int         checks = 0, failures = 0;
    bit         t_vs = 0, t_rdy = 1;
    int         t_cfg = 4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: bytes of the open line queue up; whole words leave the queue, the line end pads it.
    task automatic model_edge(input bit rst, input bit vs, input bit en,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input bit rdy, input int cfg);
        word_t nw[$];
        bit    line_done = 0;
        if (rst) begin
            m_fifo.delete(); m_line.delete();
            m_pix = 0; m_width = cfg; m_sof = 1; m_ovf = 0; m_vprev = 0;
            return;
        end
        if (vs && !m_vprev) begin
            m_line.delete(); m_pix = 0; m_width = cfg; m_sof = 1;
        end
        m_vprev = vs;
        if (en) begin
            m_line.push_back(r); m_line.push_back(g); m_line.push_back(b);
            m_pix++;
            if (m_pix == m_width) begin
                while (m_line.size() % 4 != 0) m_line.push_back(8'h00);
                m_pix = 0;
                line_done = 1;
            end
            while (m_line.size() >= 4) begin
                word_t w;
                w.data = {m_line[3], m_line[2], m_line[1], m_line[0]};
                repeat (4) void'(m_line.pop_front());
                w.sof = m_sof;
                m_sof = 0;
                w.eol = line_done && (m_line.size() == 0);
                nw.push_back(w);
                m_gen++;
            end
        end
        if (m_fifo.size() != 0 && rdy) void'(m_fifo.pop_front());
        foreach (nw[i]) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(nw[i]);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        int n = m_fifo.size();
        check("valid", pk_o_valid, n != 0);
        check("level", pk_o_level, n);
        check("ovf", pk_o_ovf, m_ovf);
        if (n != 0) begin
            check("data", pk_o_data, m_fifo[0].data);
            check("sof", pk_o_sof, m_fifo[0].sof);
            check("eol", pk_o_eol, m_fifo[0].eol);
        end else begin
            check("data_idle", pk_o_data, 0);
        end
    endtask

    task automatic step(input bit rst, input bit en, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
        @(negedge clk_scl);
        rst_scl = rst; scl_o_vsync = t_vs; scl_o_data_en = en;
        scl_o_data_r = r; scl_o_data_g = g; scl_o_data_b = b;
        pk_cfg_width = t_cfg[WW-1:0]; pk_i_ready = t_rdy;
        if (!rst && pk_o_valid && t_rdy) acc_q.push_back('{pk_o_data, pk_o_sof, pk_o_eol});
        model_edge(rst, t_vs, en, r, g, b, t_rdy, t_cfg);
        @(posedge clk_scl);
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        step(0, 1, r, g, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic vsync_pulse();
        t_vs = 1; idle(1); t_vs = 0; idle(1);
    endtask

    initial begin
        int eol_cnt, sof_cnt, start, guard;

        // Reset state
        t_cfg = 4; t_rdy = 1;
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);

        // Test 1: W=4 packs to three words
        acc_q.delete();
        cyc(8'h01, 8'h02, 8'h03); cyc(8'h04, 8'h05, 8'h06);
        cyc(8'h07, 8'h08, 8'h09); cyc(8'h0A, 8'h0B, 8'h0C);
        idle(3);
        check("t1_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("t1_w0", acc_q[0].data, 32'h04030201);
            check("t1_w1", acc_q[1].data, 32'h08070605);
            check("t1_w2", acc_q[2].data, 32'h0C0B0A09);
            check("t1_sof", {acc_q[0].sof, acc_q[1].sof, acc_q[2].sof}, 3'b100);
            check("t1_eol", {acc_q[0].eol, acc_q[1].eol, acc_q[2].eol}, 3'b001);
        end

        // Test 2: W=5 ends with one pad byte
        t_cfg = 5; vsync_pulse(); acc_q.delete();
        for (int i = 0; i < 5; i++) cyc(8'(3*i+1), 8'(3*i+2), 8'(3*i+3));
        idle(3);
        check("t2_count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            check("t2_last", acc_q[3].data, 32'h000F0E0D);
            check("t2_last_eol", acc_q[3].eol, 1);
            check("t2_first_sof", acc_q[0].sof, 1);
        end

        // Test 3: W=640, two lines at 50% duty
        t_cfg = 640; vsync_pulse(); acc_q.delete();
        for (int i = 0; i < 1280; i++) begin
            cyc(8'($urandom), 8'($urandom), 8'($urandom));
            idle(1);
        end
        idle(4);
        check("t3_count", acc_q.size(), 960);
        eol_cnt = 0; sof_cnt = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i].eol) eol_cnt++;
            if (acc_q[i].sof) sof_cnt++;
        end
        check("t3_eol_cnt", eol_cnt, 2);
        check("t3_sof_cnt", sof_cnt, 1);
        if (acc_q.size() == 960) begin
            check("t3_eol_479", acc_q[479].eol, 1);
            check("t3_eol_959", acc_q[959].eol, 1);
        end
        check("t3_ovf", pk_o_ovf, 0);

        // Test 5: vsync after 2 pixels discards the partial word
        t_cfg = 4; vsync_pulse(); acc_q.delete();
        cyc(8'h11, 8'h12, 8'h13); cyc(8'h14, 8'h15, 8'h16);
        t_vs = 1; cyc(8'h21, 8'h22, 8'h23);
        t_vs = 0; cyc(8'h24, 8'h25, 8'h26);
        idle(3);
        check("t5_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("t5_old", acc_q[0].data, 32'h14131211);
            check("t5_new", acc_q[1].data, 32'h24232221);
            check("t5_new_sof", acc_q[1].sof, 1);
        end

        // Test 4: 40 pushes against a stalled writer
        t_rdy = 0; acc_q.delete(); start = m_gen; guard = 0;
        while (m_gen - start < 40 && guard < 200) begin
            cyc(8'($urandom), 8'($urandom), 8'($urandom));
            guard++;
        end
        check("t4_level", pk_o_level, 16);
        check("t4_ovf", pk_o_ovf, 1);
        t_rdy = 1; idle(20);
        check("t4_drained", acc_q.size(), 16);
        check("t4_empty", pk_o_level, 0);

        // Test 6: reset mid-line with 7 words queued
        t_rdy = 0; guard = 0;
        while (m_fifo.size() < 7 && guard < 50) begin
            cyc(8'($urandom), 8'($urandom), 8'($urandom));
            guard++;
        end
        check("t6_level7", pk_o_level, 7);
        step(1, 0, 0, 0, 0);
        check("t6_valid", pk_o_valid, 0);
        check("t6_level", pk_o_level, 0);
        check("t6_ovf", pk_o_ovf, 0);
        t_rdy = 1; guard = 0;
        while (!pk_o_valid && guard < 10) begin
            cyc(8'($urandom), 8'($urandom), 8'($urandom));
            guard++;
        end
        check("t6_valid_after", pk_o_valid, 1);
        check("t6_sof", pk_o_sof, 1);

        // Random traffic: small widths (incl. double-push widths), random stalls and vsyncs
        for (int i = 0; i < 4000; i++) begin
            t_vs  = ($urandom_range(0, 149) == 0);
            t_cfg = $urandom_range(1, 9);
            t_rdy = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        t_vs = 0; t_rdy = 1; idle(20);
        check("end_empty", pk_o_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
